// File: rtl/spi_responder.sv
// SPI responder (CPOL=1, CPHA=0, MSB first, 8-bit frames) oversampled on clk.
// Received bytes and bytes to return are exchanged through valid/ready handshakes.
module spi_responder #(
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SPI_CLK,
    input  logic       SPI_MOSI,
    input  logic       SPI_EN,
    output logic       SPI_MISO,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [2:0] sclkSync_q;
    logic [1:0] mosiSync_q;
    logic [1:0] enSync_q;
    logic       enPrev_q;

    state_t     state_q;
    logic [3:0] bitCnt_q;
    logic [6:0] rxShift_q;
    logic [7:0] txShift_q;
    logic [7:0] holdData_q;
    logic       holdFull_q;
    logic [7:0] rxData_q;
    logic       rxValid_q;
    logic       overrun_q;

    logic       sclkFall;
    logic       sclkRise;
    logic       enLevel;
    logic       enRise;
    logic       mosiBit;
    logic       txWrite;
    logic       rxAccept;
    logic       byteDone;
    logic       reload;
    logic [7:0] rxByte_d;
    logic [7:0] reloadByte_d;

    // Presets match the idle bus (clock high, not selected) so reset creates no edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclkSync_q <= 3'b111;
            mosiSync_q <= 2'b00;
            enSync_q   <= 2'b00;
            enPrev_q   <= 1'b0;
        end else begin
            sclkSync_q <= {sclkSync_q[1:0], SPI_CLK};
            mosiSync_q <= {mosiSync_q[0], SPI_MOSI};
            enSync_q   <= {enSync_q[0], SPI_EN};
            enPrev_q   <= enSync_q[1];
        end
    end

    always_comb begin
        sclkFall     = sclkSync_q[2] & ~sclkSync_q[1];
        sclkRise     = ~sclkSync_q[2] & sclkSync_q[1];
        enLevel      = enSync_q[1];
        enRise       = enSync_q[1] & ~enPrev_q;
        mosiBit      = mosiSync_q[1];
        txWrite      = tx_valid & ~holdFull_q;
        rxAccept     = rxValid_q & rx_ready;
        rxByte_d     = {rxShift_q, mosiBit};
        byteDone     = (state_q == ACTIVE) && enLevel && sclkFall && (bitCnt_q == 4'd7);
        reload       = ((state_q == IDLE) && enRise) || byteDone;
        reloadByte_d = holdFull_q ? holdData_q : DEFAULT_TX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            rxShift_q  <= 7'd0;
            txShift_q  <= 8'd0;
            holdData_q <= 8'd0;
            holdFull_q <= 1'b0;
            rxData_q   <= 8'd0;
            rxValid_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            // A write can only land while empty, so a same-cycle reload sends DEFAULT_TX.
            if (txWrite) begin
                holdData_q <= tx_data;
                holdFull_q <= 1'b1;
            end else if (reload) begin
                holdFull_q <= 1'b0;
            end

            if (rxAccept) begin
                rxValid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enRise) begin
                        state_q   <= ACTIVE;
                        txShift_q <= reloadByte_d;
                        bitCnt_q  <= 4'd0;
                    end
                end
                ACTIVE: begin
                    if (!enLevel) begin
                        state_q  <= IDLE;
                        bitCnt_q <= 4'd0;
                    end else if (sclkFall) begin
                        rxShift_q <= rxByte_d[6:0];
                        if (bitCnt_q == 4'd7) begin
                            rxData_q  <= rxByte_d;
                            rxValid_q <= 1'b1;
                            overrun_q <= rxValid_q & ~rx_ready;
                            txShift_q <= reloadByte_d;
                            bitCnt_q  <= 4'd0;
                        end else begin
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end else if (sclkRise && (bitCnt_q >= 4'd1) && (bitCnt_q <= 4'd7)) begin
                        txShift_q <= {txShift_q[6:0], 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SPI_MISO = ((state_q == ACTIVE) && enLevel) ? txShift_q[7] : 1'b1;
    assign tx_ready = ~holdFull_q;
    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
    assign busy     = (state_q == ACTIVE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed vector table, hand-written
// corner sequences and randomized frames checked against a transaction-level model.
module tb_spi_responder;

    localparam logic [7:0] DEFAULT_TX = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic       SPI_EN;
    logic       SPI_MISO;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int halfPeriod = 8;
    int overrunCount = 0;
    logic [7:0] rxSeen[$];

    typedef struct {
        logic [7:0] mosi;
        bit         doWrite;
        logic [7:0] txByte;
        bit         consume;
        logic [7:0] expMiso;
        logic [7:0] expRx;
        int         expOverrun;
    } vec_t;

    vec_t vecs[5];

    spi_responder #(.DEFAULT_TX(DEFAULT_TX)) dut (
        .clk      (clk),
        .rst      (rst),
        .SPI_CLK  (SPI_CLK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_EN   (SPI_EN),
        .SPI_MISO (SPI_MISO),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Observe handshakes at the edge the DUT uses, before its outputs update.
    always @(posedge clk) begin
        if (overrun) overrunCount++;
        if (rx_valid && rx_ready) rxSeen.push_back(rx_data);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic writeTx(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("writeTx ready", 32'(tx_ready), 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frameStart();
        SPI_EN = 1'b1;
        repeat (halfPeriod - 2) @(negedge clk);
    endtask

    // MOSI changes two clocks ahead of each falling edge; MISO is captured at the fall.
    task automatic sendByte(input logic [7:0] b, input int nBits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            SPI_MOSI = b[7-i];
            repeat (2) @(negedge clk);
            miso = {miso[6:0], SPI_MISO};
            SPI_CLK = 1'b0;
            repeat (halfPeriod) @(negedge clk);
            SPI_CLK = 1'b1;
            repeat (halfPeriod - 2) @(negedge clk);
        end
    endtask

    task automatic frameEnd();
        SPI_EN = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic consumeRx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checkOutput("rx_valid cleared", 32'(rx_valid), 0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int ovBefore = overrunCount;
        logic [7:0] miso;
        if (v.doWrite) begin
            writeTx(v.txByte);
            checkOutput($sformatf("vec%0d tx_ready after write", idx), 32'(tx_ready), 0);
        end
        frameStart();
        checkOutput($sformatf("vec%0d busy in frame", idx), 32'(busy), 1);
        checkOutput($sformatf("vec%0d tx_ready after load", idx), 32'(tx_ready), 1);
        sendByte(v.mosi, 8, miso);
        frameEnd();
        checkOutput($sformatf("vec%0d miso byte", idx), 32'(miso), 32'(v.expMiso));
        checkOutput($sformatf("vec%0d rx_data", idx), 32'(rx_data), 32'(v.expRx));
        checkOutput($sformatf("vec%0d rx_valid", idx), 32'(rx_valid), 1);
        checkOutput($sformatf("vec%0d overrun pulses", idx), overrunCount - ovBefore, v.expOverrun);
        checkOutput($sformatf("vec%0d busy after frame", idx), 32'(busy), 0);
        checkOutput($sformatf("vec%0d idle miso", idx), 32'(SPI_MISO), 1);
        if (v.consume) consumeRx();
    endtask

    initial begin
        logic [7:0] m1;
        logic [7:0] m2;
        int ovBefore;
        bit modelPending;
        bit doWrite;
        logic [7:0] txb;
        logic [7:0] mosiB;
        logic [7:0] expMiso;
        int expOv;

        vecs[0] = '{8'h3C, 1'b1, 8'hA5, 1'b1, 8'hA5, 8'h3C, 0};
        vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 0};
        vecs[2] = '{8'h11, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h11, 0};
        vecs[3] = '{8'h22, 1'b1, 8'h96, 1'b1, 8'h96, 8'h22, 1};
        vecs[4] = '{8'hE7, 1'b1, 8'h00, 1'b1, 8'h00, 8'hE7, 0};

        rst      = 1'b1;
        SPI_CLK  = 1'b1;
        SPI_MOSI = 1'b0;
        SPI_EN   = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset SPI_MISO", 32'(SPI_MISO), 1);
        checkOutput("reset tx_ready", 32'(tx_ready), 1);
        checkOutput("reset rx_data", 32'(rx_data), 0);
        checkOutput("reset rx_valid", 32'(rx_valid), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset overrun", 32'(overrun), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Frame aborted after five bits, then a clean frame.
        ovBefore = overrunCount;
        frameStart();
        sendByte(8'hB7, 5, m1);
        SPI_EN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort busy", 32'(busy), 0);
        checkOutput("abort rx_valid", 32'(rx_valid), 0);
        frameStart();
        sendByte(8'h5A, 8, m1);
        frameEnd();
        checkOutput("post-abort rx_data", 32'(rx_data), 'h5A);
        checkOutput("post-abort rx_valid", 32'(rx_valid), 1);
        checkOutput("post-abort miso", 32'(m1), 'hFF);
        checkOutput("abort overrun", overrunCount - ovBefore, 0);
        consumeRx();

        // Two bytes in one frame; second tx byte written while the first shifts.
        rx_ready = 1'b1;
        rxSeen.delete();
        ovBefore = overrunCount;
        writeTx(8'hC3);
        checkOutput("b2b tx_ready before frame", 32'(tx_ready), 0);
        fork
            begin
                frameStart();
                sendByte(8'h6E, 8, m1);
                sendByte(8'h9B, 8, m2);
                frameEnd();
            end
            begin
                repeat (30) @(negedge clk);
                checkOutput("b2b tx_ready during byte 1", 32'(tx_ready), 1);
                writeTx(8'h81);
                checkOutput("b2b tx_ready after second write", 32'(tx_ready), 0);
            end
        join
        rx_ready = 1'b0;
        checkOutput("b2b miso byte 1", 32'(m1), 'hC3);
        checkOutput("b2b miso byte 2", 32'(m2), 'h81);
        checkOutput("b2b tx_ready after frame", 32'(tx_ready), 1);
        checkOutput("b2b rx count", rxSeen.size(), 2);
        if (rxSeen.size() == 2) begin
            checkOutput("b2b rx byte 1", 32'(rxSeen[0]), 'h6E);
            checkOutput("b2b rx byte 2", 32'(rxSeen[1]), 'h9B);
        end
        checkOutput("b2b overrun", overrunCount - ovBefore, 0);

        // Reset in the middle of a frame with rx pending and tx holding full.
        frameStart();
        sendByte(8'h99, 8, m1);
        frameEnd();
        frameStart();
        writeTx(8'h77);
        sendByte(8'hD2, 4, m1);
        checkOutput("pre-reset busy", 32'(busy), 1);
        checkOutput("pre-reset rx_valid", 32'(rx_valid), 1);
        checkOutput("pre-reset tx_ready", 32'(tx_ready), 0);
        rst    = 1'b1;
        SPI_EN = 1'b0;
        @(negedge clk);
        checkOutput("midreset SPI_MISO", 32'(SPI_MISO), 1);
        checkOutput("midreset tx_ready", 32'(tx_ready), 1);
        checkOutput("midreset rx_data", 32'(rx_data), 0);
        checkOutput("midreset rx_valid", 32'(rx_valid), 0);
        checkOutput("midreset busy", 32'(busy), 0);
        checkOutput("midreset overrun", 32'(overrun), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        frameStart();
        sendByte(8'hF0, 8, m1);
        frameEnd();
        checkOutput("post-reset rx_data", 32'(rx_data), 'hF0);
        checkOutput("post-reset rx_valid", 32'(rx_valid), 1);
        checkOutput("post-reset miso", 32'(m1), 'hFF);
        consumeRx();

        // Random frames against a transaction-level model of the handshakes.
        modelPending = 1'b0;
        for (int i = 0; i < 24; i++) begin
            doWrite    = 1'($urandom_range(0, 1));
            txb        = 8'($urandom);
            mosiB      = 8'($urandom);
            halfPeriod = int'($urandom_range(4, 10));
            if ($urandom_range(0, 3) == 0) begin
                SPI_CLK = 1'b0;
                repeat (5) @(negedge clk);
                SPI_CLK = 1'b1;
                repeat (5) @(negedge clk);
            end
            if (doWrite) writeTx(txb);
            expMiso = doWrite ? txb : DEFAULT_TX;
            ovBefore = overrunCount;
            frameStart();
            sendByte(mosiB, 8, m1);
            frameEnd();
            expOv = modelPending ? 1 : 0;
            modelPending = 1'b1;
            checkOutput($sformatf("rand%0d miso", i), 32'(m1), 32'(expMiso));
            checkOutput($sformatf("rand%0d rx_data", i), 32'(rx_data), 32'(mosiB));
            checkOutput($sformatf("rand%0d rx_valid", i), 32'(rx_valid), 1);
            checkOutput($sformatf("rand%0d overrun", i), overrunCount - ovBefore, expOv);
            checkOutput($sformatf("rand%0d tx_ready", i), 32'(tx_ready), 1);
            if ($urandom_range(0, 2) != 0) begin
                consumeRx();
                modelPending = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI target (responder) end of the SPI_driver link: mode CPOL=1/CPHA=0, MSB first, 8-bit frames, SPI_EN active-high select.
- Oversamples SPI_CLK/SPI_MOSI/SPI_EN on the system clock.
- Receives bytes on SPI_MOSI into an rx register with a valid/ready handshake.
- Returns bytes on SPI_MISO from a one-deep tx holding register loaded through a valid/ready handshake.

Parameters:
DEFAULT_TX, 8'hFF, byte shifted out when no tx byte is pending at frame/byte start.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
SPI_CLK  input  1  serial clock from initiator; idles high; async to clk.
SPI_MOSI  input  1  serial data from initiator; async.
SPI_EN  input  1  active-high frame select from initiator; async.
SPI_MISO  output  1  serial data to initiator.
tx_data  input  8  byte to return in the next frame.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  holding register empty; transfer on tx_valid&&tx_ready.
rx_data  output  8  last received byte.
rx_valid  output  1  rx_data valid; held until rx_ready.
rx_ready  input  1  consumer accepts rx_data.
busy  output  1  frame in progress (state ACTIVE).
overrun  output  1  one-cycle pulse: byte completed while rx_valid still high.

Behaviour:
- Reset (rst high at a clk edge): SPI_MISO=1, tx_ready=1, rx_data=0, rx_valid=0, busy=0, overrun=0. Holding register, shift registers and bit counter clear. Synchronizer stages preset to SPI_CLK=1, SPI_EN=0. Reset mid-frame aborts the frame silently.
- Sync: SPI_CLK, SPI_MOSI, SPI_EN each pass two flops, plus a third SPI_CLK flop for edge detection. fall = prev 1 and now 0; rise = prev 0 and now 1. Input-to-action latency is 3 clk.
- Legal SPI_CLK half-period is >=4 clk. A half-period of 8 clk, as the team's driver produces, must work.
- States:
  - IDLE: on synced EN rising, go to ACTIVE. Load tx_shift from the holding register if full (which sets tx_ready=1), else load DEFAULT_TX. Set bit_cnt=0.
  - ACTIVE, on fall: rx_shift <= {rx_shift[6:0], MOSI}; bit_cnt++.
  - ACTIVE, on rise with bit_cnt in 1..7: tx_shift <= {tx_shift[6:0], 1'b0}. Rise at bit_cnt 0 or 8 is ignored; this covers the trailing edge and CPOL idle.
  - ACTIVE, on the fall that brings bit_cnt to 8: rx_data <= completed byte; rx_valid <= 1. If rx_valid was already 1 and rx_ready=0 that cycle, pulse overrun and overwrite rx_data. Reload tx_shift exactly as in IDLE and set bit_cnt=0 for a back-to-back byte.
  - ACTIVE, on synced EN low: return to IDLE. A partial byte (bit_cnt 1..7) is discarded with no rx_valid. A tx_shift byte loaded from the holding register is consumed, not restored.
- SPI_MISO = tx_shift[7] while synced EN high, else 1. MSB is valid 3 clk after EN, before the first falling edge.
- tx handshake: tx_valid&&tx_ready writes the holding register; tx_ready falls next cycle. If a reload and a write occur in the same cycle, the reload takes the old content and the new byte is stored, leaving tx_ready=0. If the register was empty, the new byte waits for the next load.
- rx handshake: rx_valid clears on rx_valid&&rx_ready. If a byte completes in the same cycle, rx_valid stays 1 with new data and no overrun.
- busy = (state==ACTIVE).
- Glitch rule: fall/rise edges seen while in IDLE are ignored.

Test Plan:
1. Reset, write tx_data=8'hA5. Initiator (half-period 8 clk) sends 8'h3C. Expected: rx_data=8'h3C, rx_valid=1. Bits sampled on MISO at falling edges = 1010_0101. tx_ready back to 1.
2. No tx byte written, initiator sends 8'h00. Expected: MISO stream = 8'hFF (DEFAULT_TX), rx_data=8'h00.
3. Two frames 8'h11 then 8'h22 with rx_ready held 0. Expected: overrun pulses one cycle at the second completion, rx_data=8'h22, rx_valid stays 1. Then rx_ready=1 for 1 cycle clears rx_valid.
4. EN dropped after 5 falling edges. Expected: no rx_valid, busy=0 within 3 clk. The next full frame 8'h5A is received correctly.
5. EN held across 16 clocks with tx bytes 8'hC3 then 8'h81 (second written during the first byte). Expected: rx gets both bytes, MISO returns C3 then 81, tx_ready sequencing is correct.
6. rst asserted mid-frame at bit 4. Expected: all outputs return to reset values next cycle. A subsequent frame 8'hF0 is received intact.
